line_mem_model: RTL and testbench
=================================

// Module: line_mem_model
// PURPOSE
//  Synthesizable backing-memory model that sits directly downstream of
//  core_l1d_l1i's memory port. It replaces the ad-hoc combinational ack logic
//  in simulation tops. Accepts one 128-bit line request at a time (load or
//  store), waits a programmable latency, then returns a one-cycle response
//  pulse with load data. Also keeps sticky error flags and a request counter
//  for bench checks.
// PARAMETERS
//  LATENCY    1   cycles from request accept to mem_rsp_valid (1..255; 0 is treated as 1)
//  ADDR_BITS  20  byte-address bits backed by storage (2^(ADDR_BITS-4) lines of 128b)
//  INIT_NOP   1   1: initial contents are 32'h00000013 in every word; 0: all zero
// PORTS
//  clk                 in   1    clock; all state changes on posedge
//  reset               in   1    synchronous, active-high
//  mem_req_valid       in   1    request present; core holds it high until it sees the ack
//  mem_req_addr        in   64   byte address; bits [3:0] ignored (line aligned)
//  mem_req_opcode      in   4    4 = line load, 7 = line store, anything else is illegal
//  mem_req_store_data  in   128  store line data, sampled at accept
//  mem_rsp_valid       out  1    one-cycle response pulse
//  mem_rsp_load_data   out  128  load line data; valid only when mem_rsp_valid=1
//  busy                out  1    FSM not in IDLE
//  bad_opcode          out  1    sticky: an illegal opcode was accepted
//  oob_access          out  1    sticky: address >= 2^ADDR_BITS was accepted
//  req_count           out  32   number of accepted requests; wraps at 2^32
// BEHAVIOUR
//  Reset values: mem_rsp_valid=0, mem_rsp_load_data=0, busy=0, bad_opcode=0,
//  oob_access=0, req_count=0, FSM=IDLE. Reset does not clear the storage array.
//  Reset asserted mid-transaction aborts it: no response is issued, and a
//  pending store is not written.
//  FSM states: IDLE -> WAIT -> RESP -> COOL -> IDLE.
//   IDLE: if mem_req_valid=1, latch addr, opcode and store data; load the
//         counter with LATENCY-1; increment req_count; go to WAIT. If the
//         latched counter is 0, go straight to RESP.
//   WAIT: decrement the counter; at 0, go to RESP. Input changes are ignored.
//   RESP: mem_rsp_valid=1 for exactly this cycle.
//         Load: data = line[addr[ADDR_BITS-1:4]].
//         Store: write the array at this edge; data = 0.
//         Go to COOL.
//   COOL: mem_rsp_valid=0; mem_req_valid is ignored for this cycle so the
//         core's deassertion can land; go to IDLE.
//  Latency: accept at edge N gives mem_rsp_valid high during cycle N+LATENCY.
//   Minimum accept-to-accept spacing is LATENCY+2 cycles.
//  mem_rsp_load_data holds its value outside RESP. It is only updated on a
//   load or bad-opcode response.
//  Illegal opcode: set bad_opcode; still respond, with data 0 and no array
//   write, so the core never hangs.
//  Out of range (addr[63:ADDR_BITS] != 0): set oob_access. A load returns 0;
//   a store is dropped. The response is issued normally.
//  Load and store to the same line back-to-back: the load sees the stored data.
//  If mem_req_valid falls before accept, nothing happens (no partial request).
//  Sticky flags clear only on reset. The LATENCY counter is 8 bits.
// TESTING
//  1 Reset then load of addr 0x1000 with LATENCY=1 -> rsp pulse 1 cycle after
//    accept; data = {4{32'h00000013}}; req_count=1.
//  2 Store 0x1020 with data 128'hDEAD..BEEF, then load 0x1028 -> load returns
//    128'hDEAD..BEEF (low 4 addr bits ignored).
//  3 LATENCY=5, hold mem_req_valid high through the response -> exactly one
//    pulse at accept+5; the next accept is no earlier than accept+7.
//  4 Opcode 4'd2 at 0x40 -> bad_opcode=1 stays set, rsp pulse with data 0,
//    line 0x40 unchanged.
//  5 Load at 64'h1_0000_0000 (ADDR_BITS=20) -> oob_access=1, data 0; a store
//    there leaves every in-range line unchanged.
//  6 Assert reset during WAIT of a store -> no rsp pulse, line unchanged,
//    all outputs return to reset values.

Source files
------------

// File: rtl/line_mem_model.sv
// Line-granular backing memory with programmable response latency, sitting below the L1 memory port.
// One request in flight at a time; sticky error flags and an accept counter are kept for checks.
module line_mem_model #(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned ADDR_BITS = 20,
    parameter bit          INIT_NOP  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_req_valid,
    input  logic [63:0]  mem_req_addr,
    input  logic [3:0]   mem_req_opcode,
    input  logic [127:0] mem_req_store_data,
    output logic         mem_rsp_valid,
    output logic [127:0] mem_rsp_load_data,
    output logic         busy,
    output logic         bad_opcode,
    output logic         oob_access,
    output logic [31:0]  req_count
);

    localparam int unsigned LINE_W  = 128;
    localparam int unsigned IDX_W   = ADDR_BITS - 4;
    localparam int unsigned LINES   = 1 << IDX_W;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LAT_EFF = (LATENCY == 0) ? 1 : ((LATENCY > 255) ? 255 : LATENCY);

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LAT_EFF - 1);
    localparam logic [3:0]        OP_LOAD   = 4'd4;
    localparam logic [3:0]        OP_STORE  = 4'd7;
    localparam logic [LINE_W-1:0] INIT_LINE = INIT_NOP ? {4{32'h00000013}} : {LINE_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_COOL
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [3:0]        op;
        logic              oob;
        logic [LINE_W-1:0] data;
    } req_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    req_t               r_req;
    req_t               w_in_req;
    req_t               w_sel_req;
    logic               w_in_bad;
    logic               w_rsp_upd;
    logic [LINE_W-1:0]  w_rsp_data;
    logic               r_rsp_valid;
    logic [LINE_W-1:0]  r_rsp_data;
    logic               r_busy;
    logic               r_bad_opcode;
    logic               r_oob_access;
    logic [31:0]        r_req_count;

    // Storage holds line XOR init pattern, so power-up zeroed cells read back as the init pattern.
    logic [LINE_W-1:0]  r_mem [LINES];

    always_comb begin
        w_in_req.idx  = mem_req_addr[ADDR_BITS-1:4];
        w_in_req.op   = mem_req_opcode;
        w_in_req.oob  = ((mem_req_addr >> ADDR_BITS) != 64'd0);
        w_in_req.data = mem_req_store_data;
        w_in_bad      = (mem_req_opcode != OP_LOAD) && (mem_req_opcode != OP_STORE);
    end

    // Next-state logic; a zero reload skips WAIT entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (CNT_LOAD == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_COOL;
            ST_COOL: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response data is computed on entry to RESP; the request may still be on the inputs.
    always_comb begin
        w_sel_req  = (r_state == ST_IDLE) ? w_in_req : r_req;
        w_rsp_upd  = (w_state_nxt == ST_RESP) && (w_sel_req.op != OP_STORE);
        w_rsp_data = '0;
        if ((w_sel_req.op == OP_LOAD) && !w_sel_req.oob) begin
            w_rsp_data = r_mem[w_sel_req.idx] ^ INIT_LINE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_busy       <= 1'b0;
            r_bad_opcode <= 1'b0;
            r_oob_access <= 1'b0;
            r_req_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_req       <= w_in_req;
                r_req_count <= r_req_count + 32'd1;
                if (w_in_bad) begin
                    r_bad_opcode <= 1'b1;
                end
                if (w_in_req.oob) begin
                    r_oob_access <= 1'b1;
                end
            end
            if (w_rsp_upd) begin
                r_rsp_data <= w_rsp_data;
            end
        end
    end

    // Store commits at the end of RESP; reset in the same cycle cancels it.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_RESP) && (r_req.op == OP_STORE) && !r_req.oob) begin
            r_mem[r_req.idx] <= r_req.data ^ INIT_LINE;
        end
    end

    assign mem_rsp_valid     = r_rsp_valid;
    assign mem_rsp_load_data = r_rsp_data;
    assign busy              = r_busy;
    assign bad_opcode        = r_bad_opcode;
    assign oob_access        = r_oob_access;
    assign req_count         = r_req_count;

endmodule

// File: tb/tb_line_mem_model.sv
// Directed bench for line_mem_model: one instance at LATENCY=1, one at LATENCY=5.
module tb_line_mem_model;

    localparam logic [127:0] NOP_LINE = {4{32'h00000013}};
    localparam logic [127:0] D_LINE   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [127:0] E_LINE   = 128'hA5A5_5A5A_F0F0_0F0F_1234_5678_9ABC_DEF0;
    localparam logic [127:0] S_LINE   = 128'h5555_AAAA_3333_CCCC_7777_8888_9999_6666;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_a, valid_a, rsp_valid_a, busy_a, bad_a, oob_a;
    logic [63:0]  addr_a;
    logic [3:0]   op_a;
    logic [127:0] wd_a, rsp_data_a;
    logic [31:0]  count_a;

    logic         reset_b, valid_b, rsp_valid_b, busy_b, bad_b, oob_b;
    logic [63:0]  addr_b;
    logic [3:0]   op_b;
    logic [127:0] wd_b, rsp_data_b;
    logic [31:0]  count_b;

    int total = 0;
    int bad   = 0;
    int pulses;
    logic [127:0] rd;

    line_mem_model #(.LATENCY(1), .ADDR_BITS(20), .INIT_NOP(1'b1)) u_dut_a (
        .clk(clk), .reset(reset_a),
        .mem_req_valid(valid_a), .mem_req_addr(addr_a), .mem_req_opcode(op_a),
        .mem_req_store_data(wd_a),
        .mem_rsp_valid(rsp_valid_a), .mem_rsp_load_data(rsp_data_a),
        .busy(busy_a), .bad_opcode(bad_a), .oob_access(oob_a), .req_count(count_a)
    );

    line_mem_model #(.LATENCY(5), .ADDR_BITS(20), .INIT_NOP(1'b1)) u_dut_b (
        .clk(clk), .reset(reset_b),
        .mem_req_valid(valid_b), .mem_req_addr(addr_b), .mem_req_opcode(op_b),
        .mem_req_store_data(wd_b),
        .mem_rsp_valid(rsp_valid_b), .mem_rsp_load_data(rsp_data_b),
        .busy(busy_b), .bad_opcode(bad_b), .oob_access(oob_b), .req_count(count_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One LATENCY=1 transaction: accept, one-cycle pulse, cool-down, back in IDLE.
    task automatic run_a(input logic [3:0] op, input logic [63:0] addr,
                         input logic [127:0] wd, output logic [127:0] data);
        valid_a = 1'b1;
        op_a    = op;
        addr_a  = addr;
        wd_a    = wd;
        step();
        chk("a_rsp_pulse", 128'(rsp_valid_a), 128'd1);
        data    = rsp_data_a;
        valid_a = 1'b0;
        step();
        chk("a_rsp_one_cycle", 128'(rsp_valid_a), 128'd0);
        step();
    endtask

    initial begin
        reset_a = 1'b1; valid_a = 1'b0; addr_a = '0; op_a = '0; wd_a = '0;
        reset_b = 1'b1; valid_b = 1'b0; addr_b = '0; op_b = '0; wd_b = '0;
        step();
        step();
        reset_a = 1'b0;

        chk("a_reset_rsp_valid", 128'(rsp_valid_a), 128'd0);
        chk("a_reset_rsp_data", rsp_data_a, 128'd0);
        chk("a_reset_busy", 128'(busy_a), 128'd0);
        chk("a_reset_bad_opcode", 128'(bad_a), 128'd0);
        chk("a_reset_oob", 128'(oob_a), 128'd0);
        chk("a_reset_count", 128'(count_a), 128'd0);

        run_a(4'd4, 64'h1000, '0, rd);
        chk("t1_load_init", rd, NOP_LINE);
        chk("t1_count", 128'(count_a), 128'd1);

        run_a(4'd7, 64'h1020, D_LINE, rd);
        run_a(4'd4, 64'h1028, '0, rd);
        chk("t2_store_then_load", rd, D_LINE);
        chk("t2_count", 128'(count_a), 128'd3);

        run_a(4'd2, 64'h40, E_LINE, rd);
        chk("t4_bad_data_zero", rd, 128'd0);
        chk("t4_bad_flag", 128'(bad_a), 128'd1);
        chk("t4_no_oob", 128'(oob_a), 128'd0);
        run_a(4'd4, 64'h40, '0, rd);
        chk("t4_line_unchanged", rd, NOP_LINE);
        chk("t4_bad_sticky", 128'(bad_a), 128'd1);

        run_a(4'd4, 64'h1_0000_0000, '0, rd);
        chk("t5_oob_load_zero", rd, 128'd0);
        chk("t5_oob_flag", 128'(oob_a), 128'd1);
        run_a(4'd7, 64'h1_0000_1020, E_LINE, rd);
        run_a(4'd7, 64'h1_0000_1000, E_LINE, rd);
        run_a(4'd4, 64'h1020, '0, rd);
        chk("t5_alias_1020_intact", rd, D_LINE);
        run_a(4'd4, 64'h1000, '0, rd);
        chk("t5_alias_1000_intact", rd, NOP_LINE);
        chk("t5_oob_sticky", 128'(oob_a), 128'd1);
        chk("t5_count", 128'(count_a), 128'd10);
        chk("a_data_held_idle", rsp_data_a, NOP_LINE);

        // LATENCY=5 instance: request held high across the whole response.
        reset_b = 1'b0;
        step();
        chk("b_reset_count", 128'(count_b), 128'd0);
        chk("b_reset_busy", 128'(busy_b), 128'd0);
        valid_b = 1'b1; op_b = 4'd4; addr_b = 64'h2000; wd_b = '0;
        step();
        chk("t3_accept_busy", 128'(busy_b), 128'd1);
        chk("t3_accept_count", 128'(count_b), 128'd1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid_b) pulses++;
            if (k < 3) step();
        end
        chk("t3_no_early_pulse", 128'(pulses), 128'd0);
        step();
        chk("t3_pulse_at_lat5", 128'(rsp_valid_b), 128'd1);
        chk("t3_load_data", rsp_data_b, NOP_LINE);
        step();
        chk("t3_pulse_one_cycle", 128'(rsp_valid_b), 128'd0);
        step();
        chk("t3_no_accept_at_6", 128'(count_b), 128'd1);
        chk("t3_idle_at_6", 128'(busy_b), 128'd0);
        step();
        chk("t3_accept_at_7", 128'(count_b), 128'd2);
        valid_b = 1'b0;
        step();
        step();
        step();
        step();
        chk("t3_second_pulse", 128'(rsp_valid_b), 128'd1);
        step();
        step();

        valid_b = 1'b1; op_b = 4'd7; addr_b = 64'h2000; wd_b = S_LINE;
        step();
        valid_b = 1'b0;
        step();
        chk("t6_in_wait", 128'(busy_b), 128'd1);
        reset_b = 1'b1;
        step();
        chk("t6_reset_rsp_valid", 128'(rsp_valid_b), 128'd0);
        chk("t6_reset_rsp_data", rsp_data_b, 128'd0);
        chk("t6_reset_busy", 128'(busy_b), 128'd0);
        chk("t6_reset_bad", 128'(bad_b), 128'd0);
        chk("t6_reset_oob", 128'(oob_b), 128'd0);
        chk("t6_reset_count", 128'(count_b), 128'd0);
        reset_b = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rsp_valid_b) pulses++;
        end
        chk("t6_no_pulse_after_abort", 128'(pulses), 128'd0);
        valid_b = 1'b1; op_b = 4'd4; addr_b = 64'h2000; wd_b = '0;
        step();
        valid_b = 1'b0;
        step();
        step();
        step();
        step();
        chk("t6_reload_pulse", 128'(rsp_valid_b), 128'd1);
        chk("t6_line_unchanged", rsp_data_b, NOP_LINE);
        chk("t6_count_after_reset", 128'(count_b), 128'd1);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
